operand_feeder: RTL

OPERAND_FEEDER -- requirements
Module: operand_feeder

---
 rtl/operand_feeder_pkg.sv | 16 +
 rtl/operand_feeder_word_fifo.sv | 60 ++++++
 rtl/operand_feeder.sv | 109 ++++++++++
 3 files changed

// File: rtl/operand_feeder_pkg.sv
// Shared definitions for the operand feeder and the downstream summing FSM:
// burst sequencing states plus default burst size, buffer depth and dv gap.
package operand_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST    = 2'd1,
        COOLDOWN = 2'd2
    } feed_state_e;

    localparam int DATA_W      = 32;
    localparam int NR_INPS_DEF = 4;
    localparam int DEPTH_DEF   = 8;
    localparam int GAP_DEF     = NR_INPS_DEF + 2;

endpackage

// File: rtl/operand_feeder_word_fifo.sv
// word_fifo: synchronous DEPTH x 32 FIFO with push/pop and occupancy count.
// Ports: clk, reset (async, active-high), push/wr_data, pop/rd_data (head
// word, valid whenever level > 0), level (0..DEPTH).
module word_fifo
    import operand_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/operand_feeder.sv
// operand_feeder: buffers upstream words and replays them as NR_INPS-word
// bursts (dv on the first word) to a summing FSM, spaced at least GAP cycles.
// Ports: clk, reset (async, active-high), in_data/in_valid/in_ready upstream,
// dv/inpB burst output, busy (burst or cooldown), level (buffer occupancy).
module operand_feeder
    import operand_feeder_pkg::*;
#(
    parameter int NR_INPS = NR_INPS_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int GAP     = NR_INPS + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   dv,
    output logic [DATA_W-1:0]      inpB,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int CW   = $clog2(GAP + 1);
    localparam int COOL = GAP - NR_INPS;

    feed_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] inpB_q, inpB_d;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     fifo_level;

    word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head),
        .level   (fifo_level)
    );

    // Ready depends only on the registered occupancy (and reset).
    assign in_ready = !reset && (fifo_level < LW'(DEPTH));
    assign push     = in_valid && in_ready;

    // Word 0 is popped on the IDLE->BURST decision so the registered inpB
    // already holds it in the first BURST cycle, aligned with dv. The
    // remaining words are popped in the first NR_INPS-1 BURST cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_level >= LW'(NR_INPS)) begin
                    pop     = 1'b1;
                    state_d = BURST;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (cnt_q == CW'(NR_INPS - 1)) begin
                    cnt_d   = '0;
                    state_d = (COOL > 0) ? COOLDOWN : IDLE;
                end else begin
                    pop   = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COOLDOWN: begin
                if (cnt_q == CW'(COOL - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        inpB_d = pop ? head : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            inpB_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inpB_q  <= inpB_d;
        end
    end

    assign dv    = (state_q == BURST) && (cnt_q == '0);
    assign inpB  = inpB_q;
    assign busy  = (state_q != IDLE);
    assign level = fifo_level;

endmodule
